// File: rtl/cmd_stim_gen_if.sv
// Payload handshake bundle between the command generator (master) and the first dut stage (slave).
interface cmd_stim_gen_if #(
  parameter int CMD_W  = 2,
  parameter int ADR_W  = 3,
  parameter int DATA_W = 3
);
  logic              out_valid;
  logic              out_ready;
  logic [CMD_W-1:0]  out_cmd;
  logic [ADR_W-1:0]  out_adr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid, out_cmd, out_adr, out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_cmd, out_adr, out_data,
    output out_ready
  );
endinterface

// File: rtl/cmd_stim_gen.sv
// Seeded LFSR command generator with valid/ready backpressure.
// Optional address-coverage bitmap enabled by defining CMD_STIM_GEN_COV_EN.
module cmd_stim_gen #(
  parameter int CMD_W    = 2,
  parameter int ADR_W    = 3,
  parameter int DATA_W   = 3,
  parameter int CMD_VAL  = 2,
  parameter int ADR_LO   = 3,
  parameter int ADR_HI   = 4,
  parameter int DATA_MAX = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         seed,
  input  logic [15:0]         num_txn,
  input  logic                mode,
  output logic                busy,
  output logic                done,
  cmd_stim_gen_if.master      bus,
  output logic [ADR_W:0]      cov_count,
  output logic                cov_full
);

  localparam int          R        = ADR_HI - ADR_LO + 1;
  localparam int          APW      = 17 + ADR_W;
  localparam int          DPW      = 17 + DATA_W;
  localparam logic [15:0] SEED_DEF = 16'hACE1;
  localparam logic [15:0] TAPS     = 16'hB400;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [15:0]        lfsr;
  logic [15:0]        remain;
  logic [CMD_W-1:0]   cmd_r;
  logic               mode_r;
  logic               vld;
  logic               load;
  logic               hs;
  logic [ADR_W-1:0]   adr_off;

  function automatic logic [15:0] galois_step(input logic [15:0] v);
    galois_step = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  // Maps the 16-bit LFSR onto [0, R) by fixed-point multiply, avoiding a modulo.
  function automatic logic [ADR_W-1:0] scale_adr(input logic [15:0] v);
    logic [APW-1:0] prod;
    prod      = APW'(v) * APW'(R);
    scale_adr = ADR_W'(prod >> 16);
  endfunction

  function automatic logic [DATA_W-1:0] scale_data(input logic [15:0] v);
    logic [DPW-1:0] prod;
    prod       = DPW'({v[7:0], v[15:8]}) * DPW'(DATA_MAX + 1);
    scale_data = DATA_W'(prod >> 16);
  endfunction

  assign load    = (state == IDLE) && start;
  assign hs      = vld && bus.out_ready;
  assign adr_off = scale_adr(lfsr);

  assign bus.out_valid = vld;
  assign bus.out_cmd   = cmd_r;
  assign bus.out_adr   = ADR_W'(ADR_LO) + adr_off;
  assign bus.out_data  = scale_data(lfsr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    vld     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_n = (num_txn == 16'd0) ? DONE : RUN;
      RUN: begin
        vld  = 1'b1;
        busy = 1'b1;
        if (bus.out_ready && remain == 16'd1) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr   <= SEED_DEF;
      remain <= '0;
      cmd_r  <= CMD_W'(CMD_VAL);
      mode_r <= 1'b0;
    end else if (load) begin
      lfsr   <= (seed == 16'd0) ? SEED_DEF : seed;
      remain <= num_txn;
      cmd_r  <= CMD_W'(CMD_VAL);
      mode_r <= mode;
    end else if (hs) begin
      lfsr   <= galois_step(lfsr);
      remain <= remain - 16'd1;
      if (mode_r) cmd_r <= cmd_r + CMD_W'(1);
    end
  end

`ifdef CMD_STIM_GEN_COV_EN
  logic [R-1:0] bitmap, bitmap_n;

  function automatic logic [ADR_W:0] popcnt(input logic [R-1:0] b);
    popcnt = '0;
    for (int i = 0; i < R; i++) popcnt = popcnt + (ADR_W+1)'(b[i]);
  endfunction

  always_comb begin
    bitmap_n = bitmap;
    if (load)    bitmap_n = '0;
    else if (hs) bitmap_n = bitmap | (R'(1) << adr_off);
  end

  // Count is taken from the next bitmap so it lands in the cycle after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap    <= '0;
      cov_count <= '0;
    end else begin
      bitmap    <= bitmap_n;
      cov_count <= popcnt(bitmap_n);
    end
  end

  assign cov_full = (cov_count == (ADR_W+1)'(R));
`else
  assign cov_count = '0;
  assign cov_full  = 1'b0;
`endif

endmodule

// File: doc/cmd_stim_gen.md
# cmd_stim_gen

Synthesizable, parametrised constrained-random command generator for the `dut_if` chain. It drives a stream of `cmd`/`adr`/`data` transactions into the slave side of the first `dut` stage. It replaces the fixed per-clock `$urandom_range` driver with an LFSR-based source that is reproducible from a seed and honours backpressure. Cycle-exact behaviour is identical in simulation and emulation.

## Interface
Parameters:
- `CMD_W`, 2, command width
- `ADR_W`, 3, address width
- `DATA_W`, 3, data width
- `CMD_VAL`, 2, command value issued (mode 0) / starting command (mode 1)
- `ADR_LO`, 3, lowest address issued; must satisfy 0 ≤ `ADR_LO` ≤ `ADR_HI` < 2^`ADR_W`
- `ADR_HI`, 4, highest address issued
- `DATA_MAX`, 7, highest data value issued; must be < 2^`DATA_W`

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a run; sampled only in IDLE
- `seed`  in  16  LFSR seed, sampled with `start`; 0 is replaced by 16'hACE1
- `num_txn`  in  16  transactions in the run, sampled with `start`
- `mode`  in  1  0 = constant cmd, 1 = incrementing cmd; sampled with `start`
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run
- `out_valid`  out  1  payload valid
- `out_ready`  in  1  sink accepts payload
- `out_cmd`  out  `CMD_W`  command
- `out_adr`  out  `ADR_W`  address
- `out_data`  out  `DATA_W`  data
- `cov_count`  out  `ADR_W`+1  distinct addresses issued this run (macro only)
- `cov_full`  out  1  every address in [`ADR_LO`,`ADR_HI`] issued (macro only)

## Operation
- FSM states IDLE, RUN, DONE.
- IDLE: on `start`, load `lfsr`←seed (zero-substituted), `remain`←`num_txn`, `cmd_r`←`CMD_VAL`, and latch `mode`.
  - If `num_txn`==0 → DONE.
  - Otherwise → RUN.
- RUN: `out_valid`=1. A handshake occurs on any cycle with `out_valid`&&`out_ready`. On each handshake:
  - `lfsr` advances one Galois step, taps 16'hB400 (right shift; XOR taps when shifted-out bit is 1).
  - `remain` decrements.
  - If mode 1, `cmd_r` increments modulo 2^`CMD_W`.
  - The handshake that takes `remain` from 1 to 0 → DONE.
- DONE: `done`=1 for exactly one cycle → IDLE.
- Payload is combinational from registered state and stays stable while `out_valid`&&!`out_ready`:
  - `out_cmd` = `cmd_r`.
  - `out_adr` = `ADR_LO` + ((`lfsr` × R) >> 16), where R = `ADR_HI`−`ADR_LO`+1. Unsigned product is 16+`ADR_W`+1 bits wide; result is truncated to `ADR_W`.
  - `out_data` = ({`lfsr`[7:0],`lfsr`[15:8]} × (`DATA_MAX`+1)) >> 16, truncated to `DATA_W`.
- `busy` = (state==RUN).
- `start` outside IDLE is ignored, including in DONE.
- Asynchronous `rst` at any time, including mid-run with `out_valid` high:
  - Immediately drives state to IDLE, `out_valid`, `busy`, `done`, and `cov_*` to 0.
  - Sets `lfsr` to 16'hACE1, `cmd_r` to `CMD_VAL`, `remain` to 0.
  - The in-flight payload is dropped, not completed.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_cmd`=`CMD_VAL`, `cov_count`=0, `cov_full`=0.
  - `out_adr`/`out_data` take the values derived from 16'hACE1; they are don't-care while `out_valid`=0.
- `start` at edge T → `out_valid`=1 and `busy`=1 from T+1, with payload 1 derived from the seed.
- With `out_ready` held high, N transactions take N consecutive cycles (T+1..T+N). `done` is high in T+N+1; `start` is accepted again at edge T+N+2.
- `num_txn`=0: `done` high in T+1, no `out_valid`.
- `out_ready` stalls hold all state; there is no limit on stall length.

## Configuration
- Macro `CMD_STIM_GEN_COV_EN`.
- Defined:
  - A bitmap of R bits is cleared on accepted `start` and sets bit (`out_adr`−`ADR_LO`) on each handshake.
  - `cov_count` = population count of the bitmap, registered, updated the cycle after the handshake.
  - `cov_full` = (`cov_count`==R).
  - Both hold after DONE until the next `start` or `rst`.
- Undefined: no bitmap logic; `cov_count` and `cov_full` are tied to 0.

## Test plan
- Reset mid-run: `num_txn`=8, assert `rst` after 3 handshakes → `out_valid`/`busy` 0 immediately, no `done`; a new `start` then runs the full 8 transactions.
- Default params, `seed`=16'h8000, `num_txn`=1, `out_ready`=1 → single beat `cmd`=2, `adr`=4, `data`=0; `done` pulses 2 cycles after `start`.
- `seed`=0 vs `seed`=16'hACE1, `num_txn`=16, `mode`=0 → identical payload sequences; every `adr` in {3,4}, every `data` ≤ 7, `cmd` always 2.
- `mode`=1, `num_txn`=6, `out_ready` toggling 1,0,0,1,… → `cmd` sequence 2,3,0,1,2,3; payload stable through every stall; exactly 6 handshakes before `done`.
- `num_txn`=0 → `done` at T+1, `out_valid` never high; a `start` pulse during RUN or DONE causes no restart.
- With `CMD_STIM_GEN_COV_EN`, `num_txn`=32, default params → `cov_count` reaches 2 and `cov_full`=1; after the next `start`, both clear to 0.
